// File: rtl/riscv_pkg.sv
// Shared RV64 definitions for the fetch path.
//   XLEN / INSTR_SIZE : datapath widths
//   NOP_INSTR         : addi x0,x0,0, shown to idu when no instruction is valid
//   EBREAK_INSTR      : encoding idu uses to raise ebreak
//   ifu_state_e       : fetch FSM states
//   fetch_entry_t     : one buffered fetch result {pc, instr}
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int INSTR_SIZE = 32;

  localparam logic [INSTR_SIZE-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [INSTR_SIZE-1:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [INSTR_SIZE-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer between imem responses and idu.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i/data_i: write one entry (caller guarantees not full)
//   pop_i        : drop the head entry (caller guarantees not empty)
//   flush_i      : empty the buffer; wins over push/pop
//   data_o       : head entry (registered storage, no bypass)
//   empty_o      : buffer empty
//   count_o      : number of valid entries
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ifu.sv
// RV64 instruction fetch unit feeding idu.
//   clk, rst                       : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      : in-order word fetch requests
//   imem_rsp_valid/data            : in-order responses, no backpressure
//   instr_valid/ready, instr,
//   instr_pc                       : buffered instruction stream to idu
//   redirect_valid/pc              : exu control-flow redirect
//   ebreak                         : idu flags the presented instr as ebreak
//   halted                         : fetch permanently stopped until reset
//
// state | meaning
// RUN   | normal fetch, redirects honoured
// DRAIN | ebreak consumed; waiting for in-flight responses, all discarded
// HALT  | terminal until reset
module ifu
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        ebreak,
  output logic        halted
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  ifu_state_e   state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [63:0]  rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          fifo_push, fifo_pop, fifo_flush, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry, head_entry;
  logic [CW:0]   inflight;
  logic          req_fire, pop_fire;

  assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t)),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_o  (head_entry),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Credits cover both buffered entries and requests still in flight, so a
  // kept response always has a free slot.
  assign inflight = {1'b0, fifo_count} + {1'b0, outstanding_q};

  assign instr_valid   = (state_q == RUN) && !fifo_empty;
  assign instr         = instr_valid ? head_entry.instr : NOP_INSTR;
  assign instr_pc      = fifo_empty ? rsp_pc_q : head_entry.pc;
  assign imem_req_addr = fetch_pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    rsp_pc_d       = rsp_pc_q;
    outstanding_d  = outstanding_q;
    drop_cnt_d     = drop_cnt_q;
    imem_req_valid = 1'b0;
    fifo_push      = 1'b0;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    halted         = 1'b0;
    req_fire       = 1'b0;
    pop_fire       = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          // Everything requested so far belongs to the old path; a response
          // arriving this cycle is thrown away here, the rest via drop_cnt.
          fifo_flush    = 1'b1;
          fetch_pc_d    = word_align(redirect_pc);
          rsp_pc_d      = word_align(redirect_pc);
          outstanding_d = outstanding_q - CW'(imem_rsp_valid);
          drop_cnt_d    = outstanding_q - CW'(imem_rsp_valid);
        end else begin
          imem_req_valid = !rst && (inflight < DEPTH_W);
          req_fire       = imem_req_valid && imem_req_ready;
          pop_fire       = instr_valid && instr_ready;
          if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
          outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

          if (imem_rsp_valid) begin
            if (drop_cnt_q != '0) begin
              drop_cnt_d = drop_cnt_q - CW'(1);
            end else if (!(pop_fire && ebreak)) begin
              fifo_push = 1'b1;
              rsp_pc_d  = rsp_pc_q + 64'd4;
            end
          end

          if (pop_fire) begin
            if (ebreak) begin
              fifo_flush = 1'b1;
              state_d    = DRAIN;
            end else begin
              fifo_pop = 1'b1;
            end
          end
        end
      end

      DRAIN: begin
        outstanding_d = outstanding_q - CW'(imem_rsp_valid);
        if (outstanding_d == '0) state_d = HALT;
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && (outstanding_q == '0)));
      assert (outstanding_q <= DEPTH_W[CW-1:0]);
    end
  end

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;
  import riscv_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ebreak;
  logic        halted;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ebreak         (ebreak),
    .halted         (halted)
  );

  // idu decode of ebreak on the presented instruction
  assign ebreak = instr_valid && (instr == EBREAK_INSTR);

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [63:0] pend_q[$];
  logic [63:0] hs_addrs[$];
  int          hs_count = 0;
  int          rsp_budget = 1000;
  logic [63:0] ebreak_addr = '1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == ebreak_addr) return EBREAK_INSTR;
    return {a[15:0], 16'h0033};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Instruction memory: records accepted requests at the edge and answers
  // in order, one cycle later at the earliest, limited by rsp_budget.
  always @(posedge clk) begin
    if (rst) begin
      pend_q.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back(imem_req_addr);
      hs_addrs.push_back(imem_req_addr);
      hs_count++;
    end
    #2;
    if (!rst && rsp_budget > 0 && pend_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q.pop_front());
      rsp_budget--;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  // Monitor: every consumed instruction is matched against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (instr_valid && instr_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr: got pc %h instr %h, required none", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e.pc);
          chk("instr", {32'h0, instr}, {32'h0, e.ins});
        end
      end
      if (!instr_valid) chk("nop_when_invalid", {32'h0, instr}, {32'h0, NOP_INSTR});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc  = base + 64'(4 * i);
      e.ins = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_n(input int n);
    int target;
    int cyc;
    target = hs_count + n;
    cyc = 0;
    imem_req_ready = 1'b1;
    while (hs_count < target && cyc < 100) begin
      step();
      cyc++;
    end
    imem_req_ready = 1'b0;
    chk("issue_count", 64'(hs_count), 64'(target));
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || instr_valid) && cyc < 200) begin
      step();
      cyc++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int h0;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;

    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", {32'h0, instr}, {32'h0, NOP_INSTR});
    chk("rst_instr_pc", instr_pc, RESET_PC);
    chk("rst_halted", 64'(halted), 64'd0);
    step();
    rst = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    chk("first_instr_valid", 64'(instr_valid), 64'd0);

    // 2: zero-wait stream, in-order PCs
    step();
    expect_seq(RESET_PC, 4);
    issue_n(4);
    wait_drain();

    // 3: downstream stalled, credits cap requests at depth
    instr_ready = 1'b0;
    h0 = hs_count;
    imem_req_ready = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("stall_req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall_req_count", 64'(hs_count - h0), 64'd2);
    step();
    imem_req_ready = 1'b0;
    expect_seq(RESET_PC + 64'h10, 2);
    instr_ready = 1'b1;
    wait_drain();

    // 4: redirect with two requests in flight
    rsp_budget = 0;
    issue_n(2);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1003;
    @(negedge clk);
    chk("redir_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    rsp_budget = 1000;
    hs_addrs.delete();
    expect_seq(64'h8000_1000, 3);
    issue_n(3);
    chk("redir_first_addr", (hs_addrs.size() > 0) ? hs_addrs[0] : 64'hDEAD, 64'h8000_1000);
    wait_drain();

    // 5: redirect coincides with a response and a pop; target wraps at 2^64
    instr_ready = 1'b0;
    rsp_budget = 0;
    issue_n(2);
    step();
    rsp_budget = 1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFA;
    instr_ready    = 1'b1;
    rsp_budget     = 1;
    @(negedge clk);
    chk("t5_head_valid", 64'(instr_valid), 64'd1);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t5_flushed", 64'(instr_valid), 64'd0);
    chk("t5_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    rsp_budget = 1000;
    expect_seq(64'hFFFF_FFFF_FFFF_FFF8, 3);
    step();
    issue_n(3);
    wait_drain();

    // 6: ebreak with one request in flight, then halt
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    @(negedge clk);
    chk("redir_blocks_issue", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    ebreak_addr = 64'h8000_2000;
    instr_ready = 1'b0;
    rsp_budget  = 0;
    issue_n(2);
    expect_seq(64'h8000_2000, 1);
    step();
    rsp_budget = 1;
    step();
    step();
    @(negedge clk);
    chk("ebreak_presented", {32'h0, instr}, {32'h0, EBREAK_INSTR});
    step();
    instr_ready = 1'b1;
    step();
    @(negedge clk);
    chk("drain_halted", 64'(halted), 64'd0);
    chk("drain_req_valid", 64'(imem_req_valid), 64'd0);
    chk("drain_instr_valid", 64'(instr_valid), 64'd0);
    step();
    rsp_budget = 1;
    @(negedge clk);
    chk("last_rsp_halted", 64'(halted), 64'd0);
    step();
    @(negedge clk);
    chk("halted_after_rsp", 64'(halted), 64'd1);
    h0 = hs_count;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_3000;
    repeat (2) step();
    redirect_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("halt_sticky", 64'(halted), 64'd1);
    chk("halt_req_valid", 64'(imem_req_valid), 64'd0);
    chk("halt_instr_valid", 64'(instr_valid), 64'd0);
    chk("halt_no_reqs", 64'(hs_count - h0), 64'd0);
    chk("halt_scoreboard", 64'(exp_q.size()), 64'd0);
    imem_req_ready = 1'b0;

    // 7: reset out of HALT restarts at RESET_PC
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rerst_halted", 64'(halted), 64'd0);
    chk("rerst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rerst_instr_pc", instr_pc, RESET_PC);
    step();
    rst = 1'b0;
    ebreak_addr = '1;
    rsp_budget  = 1000;
    expect_seq(RESET_PC, 2);
    issue_n(2);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
